// File: rtl/console_pkg.sv
// Shared types and constants for the console writer.
// FSM states, control codes and the cell address helper.
package console_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCR_RD,
    SCR_WAIT,
    SCR_WR,
    CLEAR,
    CLEAR_ROW
  } state_t;

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  localparam logic [15:0] C_INDEX_BASE = 16'h6000;

  function automatic logic [15:0] cell_addr(
    input logic [15:0] base,
    input logic [15:0] cols,
    input logic [4:0]  row,
    input logic [4:0]  col
  );
    return base + 16'(row) * cols + 16'(col);
  endfunction

endpackage

// File: rtl/console_writer_if.sv
// Character stream and video RAM port bundle.
// master = console writer, slave = source/RAM side.
interface console_writer_if;

  logic [7:0]  I_char_data;
  logic        I_char_valid;
  logic        O_char_ready;
  logic [15:0] O_mem_addr;
  logic [7:0]  O_mem_data;
  logic        O_mem_write;
  logic [7:0]  I_mem_data;

  modport master (
    input  I_char_data,
    input  I_char_valid,
    input  I_mem_data,
    output O_char_ready,
    output O_mem_addr,
    output O_mem_data,
    output O_mem_write
  );

  modport slave (
    output I_char_data,
    output I_char_valid,
    output I_mem_data,
    input  O_char_ready,
    input  O_mem_addr,
    input  O_mem_data,
    input  O_mem_write
  );

endinterface

// File: rtl/console_writer.sv
// Text console: turns character codes into tile index writes,
// with cursor control, clear-screen and scroll-by-copy.
module console_writer
  import console_pkg::*;
#(
  parameter logic [15:0] G_index_base   = C_INDEX_BASE,
  parameter int          G_cols         = 32,
  parameter int          G_rows         = 28,
  parameter logic [7:0]  G_blank_char   = 8'h20,
  parameter int          G_read_latency = 2
) (
  input  logic              I_clock,
  input  logic              I_reset,
  console_writer_if.master  bus,
  output logic [4:0]        O_cursor_col,
  output logic [4:0]        O_cursor_row,
  output logic              O_busy
);

  localparam logic [15:0] L_cols = 16'(G_cols);
  localparam logic [4:0]  L_col_last = 5'(G_cols - 1);
  localparam logic [4:0]  L_row_last = 5'(G_rows - 1);
  localparam logic [15:0] L_copy_last = 16'((G_rows - 1) * G_cols - 1);
  localparam logic [15:0] L_clear_last = 16'(G_rows * G_cols - 1);
  localparam logic [15:0] L_last_row = 16'(G_index_base + 16'((G_rows - 1) * G_cols));
  localparam logic [15:0] L_src_base = G_index_base + L_cols;
  localparam logic [7:0]  L_wait_last = 8'(G_read_latency - 1);

  state_t      state, state_n;
  logic [4:0]  col, col_n;
  logic [4:0]  row, row_n;
  logic [15:0] idx, idx_n;
  logic [7:0]  wcnt, wcnt_n;
  logic        pend, pend_n;
  logic [15:0] addr_n;
  logic [7:0]  data_n;
  logic        write_n;
  logic        go_wr;
  logic [7:0]  ch;

  assign ch = bus.I_char_data;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state            <= IDLE;
      col              <= '0;
      row              <= '0;
      idx              <= '0;
      wcnt             <= '0;
      pend             <= 1'b0;
      bus.O_mem_addr   <= '0;
      bus.O_mem_data   <= '0;
      bus.O_mem_write  <= 1'b0;
      bus.O_char_ready <= 1'b1;
      O_busy           <= 1'b0;
    end else begin
      state            <= state_n;
      col              <= col_n;
      row              <= row_n;
      idx              <= idx_n;
      wcnt             <= wcnt_n;
      pend             <= pend_n;
      bus.O_mem_addr   <= addr_n;
      bus.O_mem_data   <= data_n;
      bus.O_mem_write  <= write_n;
      bus.O_char_ready <= (state_n == IDLE);
      O_busy           <= (state_n == SCR_RD) || (state_n == SCR_WAIT) ||
                          (state_n == SCR_WR) || (state_n == CLEAR) ||
                          (state_n == CLEAR_ROW);
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    idx_n   = idx;
    wcnt_n  = wcnt;
    pend_n  = pend;
    addr_n  = bus.O_mem_addr;
    data_n  = bus.O_mem_data;
    write_n = 1'b0;
    go_wr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.I_char_valid) begin
          unique case (1'b1)
            (ch >= 8'h20): begin
              state_n = WRITE;
              addr_n  = cell_addr(G_index_base, L_cols, row, col);
              data_n  = ch;
              write_n = 1'b1;
              pend_n  = 1'b0;
              if (col == L_col_last) begin
                col_n = '0;
                if (row == L_row_last) pend_n = 1'b1;
                else row_n = row + 5'd1;
              end else begin
                col_n = col + 5'd1;
              end
            end
            (ch == C_CR): col_n = '0;
            (ch == C_LF): begin
              col_n = '0;
              if (row == L_row_last) begin
                state_n = SCR_RD;
                idx_n   = '0;
                addr_n  = L_src_base;
              end else begin
                row_n = row + 5'd1;
              end
            end
            (ch == C_BS): begin
              if (col != 5'd0) begin
                col_n   = col - 5'd1;
                state_n = WRITE;
                pend_n  = 1'b0;
                addr_n  = cell_addr(G_index_base, L_cols, row, col - 5'd1);
                data_n  = G_blank_char;
                write_n = 1'b1;
              end
            end
            (ch == C_FF): begin
              state_n = CLEAR;
              idx_n   = '0;
              addr_n  = G_index_base;
              data_n  = G_blank_char;
              write_n = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (pend) begin
          state_n = SCR_RD;
          idx_n   = '0;
          addr_n  = L_src_base;
        end else begin
          state_n = IDLE;
        end
      end
      SCR_RD: begin
        wcnt_n = 8'd1;
        if (L_wait_last == 8'd0) go_wr = 1'b1;
        else state_n = SCR_WAIT;
      end
      SCR_WAIT: begin
        if (wcnt >= L_wait_last) go_wr = 1'b1;
        else wcnt_n = wcnt + 8'd1;
      end
      SCR_WR: begin
        if (idx == L_copy_last) begin
          state_n = CLEAR_ROW;
          idx_n   = '0;
          addr_n  = L_last_row;
          data_n  = G_blank_char;
          write_n = 1'b1;
        end else begin
          state_n = SCR_RD;
          idx_n   = idx + 16'd1;
          addr_n  = L_src_base + idx + 16'd1;
        end
      end
      CLEAR: begin
        if (idx == L_clear_last) begin
          state_n = IDLE;
          col_n   = '0;
          row_n   = '0;
        end else begin
          idx_n   = idx + 16'd1;
          addr_n  = G_index_base + idx + 16'd1;
          write_n = 1'b1;
        end
      end
      CLEAR_ROW: begin
        if (idx == L_cols - 16'd1) begin
          state_n = IDLE;
        end else begin
          idx_n   = idx + 16'd1;
          addr_n  = L_last_row + idx + 16'd1;
          write_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // read data is sampled on the edge that enters SCR_WR
    if (go_wr) begin
      state_n = SCR_WR;
      addr_n  = G_index_base + idx;
      data_n  = bus.I_mem_data;
      write_n = 1'b1;
    end
  end

  assign O_cursor_col = col;
  assign O_cursor_row = row;

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer with a latency-2 RAM model.
module tb_console_writer;
  import console_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  console_writer_if bus();
  logic [4:0] col, row;
  logic busy;

  console_writer #(
    .G_index_base(16'h6000),
    .G_cols(32),
    .G_rows(28),
    .G_blank_char(8'h20),
    .G_read_latency(2)
  ) dut (
    .I_clock(clk),
    .I_reset(rst_n),
    .bus(bus),
    .O_cursor_col(col),
    .O_cursor_row(row),
    .O_busy(busy)
  );

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd_q;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.O_mem_write) mem[bus.O_mem_addr] <= bus.O_mem_data;
    rd_q <= mem[bus.O_mem_addr];
  end
  assign bus.I_mem_data = rd_q;

  logic [23:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  bit sb_off = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void expw(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endfunction

  always @(negedge clk) begin
    if (rst_n && !sb_off && bus.O_mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h",
                 bus.O_mem_addr, bus.O_mem_data);
      end else begin
        automatic logic [23:0] e = exp_q.pop_front();
        chk("write_addr", 32'(bus.O_mem_addr), 32'(e[23:8]));
        chk("write_data", 32'(bus.O_mem_data), 32'(e[7:0]));
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.O_char_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    bus.I_char_valid = 1'b1;
    bus.I_char_data  = c;
    @(negedge clk);
    bus.I_char_valid = 1'b0;
  endtask

  task automatic run_busy(input int limit, input bit scroll,
                          output int nwr, output int bad);
    int n;
    int last;
    n = 0;
    last = -1;
    nwr = 0;
    bad = 0;
    while (busy && n < limit) begin
      if (bus.O_mem_write) begin
        if (scroll && last >= 0 && nwr < 864 && n - last != 3) bad++;
        last = n;
        nwr++;
      end else if (!scroll) begin
        bad++;
      end
      n++;
      @(negedge clk);
    end
    if (n >= limit) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=%0d required=<%0d", n, limit);
    end
  endtask

  initial begin
    int nwr;
    int bad;
    bus.I_char_valid = 1'b0;
    bus.I_char_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(bus.O_mem_addr), 32'h0);
    chk("rst_data", 32'(bus.O_mem_data), 32'h0);
    chk("rst_write", 32'(bus.O_mem_write), 32'h0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.O_char_ready), 32'd1);
    rst_n = 1'b1;

    expw(16'h6000, 8'h41);
    send(8'h41);
    chk("a_ready_low", 32'(bus.O_char_ready), 32'd0);
    @(negedge clk);
    chk("a_ready_back", 32'(bus.O_char_ready), 32'd1);
    chk("a_col", 32'(col), 32'd1);
    chk("a_row", 32'(row), 32'd0);

    for (int i = 1; i <= 30; i++) begin
      expw(16'h6000 + 16'(i), 8'h61);
      send(8'h61);
    end
    expw(16'h601F, 8'h42);
    send(8'h42);
    @(negedge clk);
    chk("wrap_col", 32'(col), 32'd0);
    chk("wrap_row", 32'(row), 32'd1);

    send(8'h01);
    @(negedge clk);
    chk("ctl_col", 32'(col), 32'd0);
    chk("ctl_row", 32'(row), 32'd1);

    for (int i = 0; i < 896; i++) expw(16'h6000 + 16'(i), 8'h20);
    send(8'h0C);
    run_busy(2000, 1'b0, nwr, bad);
    chk("ff_writes", 32'(nwr), 32'd896);
    chk("ff_gaps", 32'(bad), 32'd0);
    chk("ff_col", 32'(col), 32'd0);
    chk("ff_row", 32'(row), 32'd0);
    chk("ff_ready", 32'(bus.O_char_ready), 32'd1);
    chk("ff_queue", 32'(exp_q.size()), 32'd0);

    send(8'h0D);
    chk("cr_ready", 32'(bus.O_char_ready), 32'd1);
    send(8'h08);
    @(negedge clk);
    chk("bs0_col", 32'(col), 32'd0);
    expw(16'h6000, 8'h58);
    send(8'h58);
    expw(16'h6001, 8'h59);
    send(8'h59);
    expw(16'h6001, 8'h20);
    send(8'h08);
    @(negedge clk);
    chk("bs_col", 32'(col), 32'd1);
    chk("bs_row", 32'(row), 32'd0);

    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 32; c++) begin
        pl_we   = 1'b1;
        pl_addr = 16'h6000 + 16'(32 * r + c);
        pl_data = 8'(r + 1);
        @(negedge clk);
      end
    end
    pl_we = 1'b0;
    repeat (27) send(8'h0A);
    @(negedge clk);
    chk("lf_row", 32'(row), 32'd27);
    for (int i = 0; i < 864; i++) expw(16'h6000 + 16'(i), 8'(i / 32 + 2));
    for (int j = 0; j < 32; j++) expw(16'h6360 + 16'(j), 8'h20);
    send(8'h0A);
    run_busy(5000, 1'b1, nwr, bad);
    chk("scr_writes", 32'(nwr), 32'd896);
    chk("scr_spacing", 32'(bad), 32'd0);
    chk("scr_mem0", 32'(mem[16'h6000]), 32'd2);
    chk("scr_mem26", 32'(mem[16'h6340]), 32'd28);
    chk("scr_col", 32'(col), 32'd0);
    chk("scr_row", 32'(row), 32'd27);
    chk("scr_queue", 32'(exp_q.size()), 32'd0);

    sb_off = 1'b1;
    send(8'h0A);
    repeat (100) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_write", 32'(bus.O_mem_write), 32'd0);
    chk("abort_col", 32'(col), 32'd0);
    chk("abort_row", 32'(row), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.O_char_ready), 32'd1);
    chk("rel_write", 32'(bus.O_mem_write), 32'd0);
    exp_q.delete();
    sb_off = 1'b0;
    expw(16'h6000, 8'h5A);
    send(8'h5A);
    @(negedge clk);
    chk("rel_col", 32'(col), 32'd1);
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
